// File: rtl/alto_bus_pkg.sv
// Shared Wishbone bus types for the Alto main-memory bus: widths, arbiter
// state encoding and a reusable master-side payload struct.
package alto_bus_pkg;

  localparam int unsigned ADR_W = 16;
  localparam int unsigned DAT_W = 16;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

  // Word address is [ADR_W:1]; bit 0 is implied by the byte selects.
  typedef struct packed {
    logic [ADR_W:1]     adr;
    logic               stb;
    logic               cyc;
    logic               we;
    logic [SEL_W-1:0]   sel;
    logic [DAT_W-1:0]   dat;
  } wb_master_t;

endpackage

// File: rtl/alto_wb_watchdog.sv
// Slave-cycle watchdog: counts stalled strobe cycles and flags a timeout on
// the TIMEOUT-th consecutive cycle without ack/err. TIMEOUT = 0 disables it.
module alto_wb_watchdog #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic err_i,
  output logic timeout_c
);

  localparam bit            ENABLE = (TIMEOUT != 0);
  localparam logic [TW-1:0] LIMIT  = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q;

  // A slave ack or err in the expiry cycle always wins over the timeout.
  assign timeout_c = ENABLE && stb_i && !ack_i && !err_i && !clr_i && (cnt_q == LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || !stb_i || ack_i || err_i || timeout_c) begin
      cnt_q <= '0;
    end else if (ENABLE) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

endmodule

// File: rtl/alto_wb_arbiter.sv
// Two-master Wishbone arbiter (CPU = master 0, disk DMA = master 1) in front of
// main memory. Grants are registered and held for the whole cyc.
module alto_wb_arbiter
  import alto_bus_pkg::*;
#(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned TW          = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic [ADR_W:1]   m0_adr_i,
  input  logic             m0_stb_i,
  input  logic             m0_cyc_i,
  input  logic             m0_we_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,

  input  logic [ADR_W:1]   m1_adr_i,
  input  logic             m1_stb_i,
  input  logic             m1_cyc_i,
  input  logic             m1_we_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,

  output logic [ADR_W:1]   s_adr_o,
  output logic             s_stb_o,
  output logic             s_cyc_o,
  output logic             s_we_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,

  output logic [1:0]       gnt_o
);

  wb_master_t m0, m1, sel_m;
  arb_state_e state_q;
  logic [1:0] gnt_q;
  logic       last_q;   // 1 = master 1 owned the bus most recently
  logic       granted;
  logic       wd_timeout;

  assign m0 = '{adr: m0_adr_i, stb: m0_stb_i, cyc: m0_cyc_i, we: m0_we_i, sel: m0_sel_i, dat: m0_dat_i};
  assign m1 = '{adr: m1_adr_i, stb: m1_stb_i, cyc: m1_cyc_i, we: m1_we_i, sel: m1_sel_i, dat: m1_dat_i};

  // Grant FSM: every ownership change passes through IDLE so s_cyc_o drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (m0.cyc && m1.cyc) begin
            if (ROUND_ROBIN && !last_q) begin
              state_q <= ARB_GNT1;
              gnt_q   <= 2'b10;
            end else begin
              state_q <= ARB_GNT0;
              gnt_q   <= 2'b01;
            end
          end else if (m0.cyc) begin
            state_q <= ARB_GNT0;
            gnt_q   <= 2'b01;
          end else if (m1.cyc) begin
            state_q <= ARB_GNT1;
            gnt_q   <= 2'b10;
          end
        end
        ARB_GNT0: begin
          if (!m0.cyc) begin
            state_q <= ARB_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b0;
          end
        end
        ARB_GNT1: begin
          if (!m1.cyc) begin
            state_q <= ARB_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  assign gnt_o = gnt_q;

  alto_wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (!granted),
    .stb_i     (s_stb_o),
    .ack_i     (s_ack_i),
    .err_i     (s_err_i),
    .timeout_c (wd_timeout)
  );

  // Slave-side mux; in IDLE master 0's payload is presented with cyc/stb low.
  always_comb begin
    granted = (state_q != ARB_IDLE);
    sel_m   = (state_q == ARB_GNT1) ? m1 : m0;
    s_adr_o = sel_m.adr;
    s_we_o  = sel_m.we;
    s_sel_o = sel_m.sel;
    s_dat_o = sel_m.dat;
    s_cyc_o = granted && sel_m.cyc;
    s_stb_o = granted && sel_m.stb;
  end

  // Responses go only to the owner; an ack racing a reset is dropped.
  always_comb begin
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    m0_ack_o = !rst_i && (state_q == ARB_GNT0) && s_ack_i;
    m1_ack_o = !rst_i && (state_q == ARB_GNT1) && s_ack_i;
    m0_err_o = !rst_i && (state_q == ARB_GNT0) && (s_err_i || wd_timeout);
    m1_err_o = !rst_i && (state_q == ARB_GNT1) && (s_err_i || wd_timeout);
  end

endmodule

// File: tb/tb_alto_wb_arbiter.sv
// Directed bench for alto_wb_arbiter: a round-robin instance with an 8-cycle
// watchdog and a fixed-priority instance with the watchdog disabled.
module tb_alto_wb_arbiter;
  import alto_bus_pkg::*;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [ADR_W:1]   m0_adr = '0, m1_adr = '0;
  logic             m0_stb = 1'b0, m0_cyc = 1'b0, m0_we = 1'b0;
  logic             m1_stb = 1'b0, m1_cyc = 1'b0, m1_we = 1'b0;
  logic [SEL_W-1:0] m0_sel = 2'b11, m1_sel = 2'b11;
  logic [DAT_W-1:0] m0_dat = '0, m1_dat = '0;
  logic [DAT_W-1:0] s_dat = '0;
  logic             s_ack = 1'b0, s_err = 1'b0;

  logic [DAT_W-1:0] d_m0_dat, d_m1_dat, d_s_dat;
  logic             d_m0_ack, d_m0_err, d_m1_ack, d_m1_err;
  logic [ADR_W:1]   d_s_adr;
  logic             d_s_stb, d_s_cyc, d_s_we;
  logic [SEL_W-1:0] d_s_sel;
  logic [1:0]       d_gnt;

  logic [DAT_W-1:0] f_m0_dat, f_m1_dat, f_s_dat;
  logic             f_m0_ack, f_m0_err, f_m1_ack, f_m1_err;
  logic [ADR_W:1]   f_s_adr;
  logic             f_s_stb, f_s_cyc, f_s_we;
  logic [SEL_W-1:0] f_s_sel;
  logic [1:0]       f_gnt;

  always #5 clk = ~clk;

  alto_wb_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(TO), .TW(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_adr_i(m0_adr), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_dat_o(d_m0_dat), .m0_ack_o(d_m0_ack), .m0_err_o(d_m0_err),
    .m1_adr_i(m1_adr), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_dat_o(d_m1_dat), .m1_ack_o(d_m1_ack), .m1_err_o(d_m1_err),
    .s_adr_o(d_s_adr), .s_stb_o(d_s_stb), .s_cyc_o(d_s_cyc), .s_we_o(d_s_we), .s_sel_o(d_s_sel),
    .s_dat_o(d_s_dat), .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(d_gnt)
  );

  alto_wb_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(0), .TW(8)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .m0_adr_i(m0_adr), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_dat_o(f_m0_dat), .m0_ack_o(f_m0_ack), .m0_err_o(f_m0_err),
    .m1_adr_i(m1_adr), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_dat_o(f_m1_dat), .m1_ack_o(f_m1_ack), .m1_err_o(f_m1_err),
    .s_adr_o(f_s_adr), .s_stb_o(f_s_stb), .s_cyc_o(f_s_cyc), .s_we_o(f_s_we), .s_sel_o(f_s_sel),
    .s_dat_o(f_s_dat), .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(f_gnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner of the bus for the next cycle, from the arbitration rules.
  function automatic logic [1:0] arb_next(input logic [1:0] g, input logic last,
                                          input logic c0, input logic c1, input logic rr);
    if (g == 2'b01) return c0 ? 2'b01 : 2'b00;
    if (g == 2'b10) return c1 ? 2'b10 : 2'b00;
    if (c0 && c1)   return (rr && !last) ? 2'b10 : 2'b01;
    if (c0)         return 2'b01;
    if (c1)         return 2'b10;
    return 2'b00;
  endfunction

  logic [1:0] mg = 2'b00, mg_fp = 2'b00, nx, nx_fp;
  logic       ml = 1'b1, ml_fp = 1'b1;
  int         stall = 0;  // stalled strobe cycles seen so far
  logic       exp_stb, exp_cyc, exp_to, fp_stb, fp_cyc;

  always_comb begin
    nx      = arb_next(mg, ml, m0_cyc, m1_cyc, 1'b1);
    nx_fp   = arb_next(mg_fp, ml_fp, m0_cyc, m1_cyc, 1'b0);
    exp_stb = (mg == 2'b01 && m0_stb) || (mg == 2'b10 && m1_stb);
    exp_cyc = (mg == 2'b01 && m0_cyc) || (mg == 2'b10 && m1_cyc);
    fp_stb  = (mg_fp == 2'b01 && m0_stb) || (mg_fp == 2'b10 && m1_stb);
    fp_cyc  = (mg_fp == 2'b01 && m0_cyc) || (mg_fp == 2'b10 && m1_cyc);
    exp_to  = exp_stb && !s_ack && !s_err && (stall + 1 == int'(TO));
  end

  always @(posedge clk) begin
    if (rst) begin
      mg <= 2'b00; ml <= 1'b1; mg_fp <= 2'b00; ml_fp <= 1'b1; stall <= 0;
    end else begin
      mg    <= nx;
      mg_fp <= nx_fp;
      if (mg != 2'b00 && nx == 2'b00)       ml    <= mg[1];
      if (mg_fp != 2'b00 && nx_fp == 2'b00) ml_fp <= mg_fp[1];
      stall <= (!exp_stb || s_ack || s_err || exp_to) ? 0 : stall + 1;
    end
  end

  logic chk_on = 1'b0;

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("gnt", d_gnt, mg);
      chk("s_cyc", d_s_cyc, exp_cyc);
      chk("s_stb", d_s_stb, exp_stb);
      chk("s_adr", d_s_adr, (mg == 2'b10) ? m1_adr : m0_adr);
      chk("s_we", d_s_we, (mg == 2'b10) ? m1_we : m0_we);
      chk("s_sel", d_s_sel, (mg == 2'b10) ? m1_sel : m0_sel);
      chk("s_dat", d_s_dat, (mg == 2'b10) ? m1_dat : m0_dat);
      chk("m0_ack", d_m0_ack, !rst && mg == 2'b01 && s_ack);
      chk("m1_ack", d_m1_ack, !rst && mg == 2'b10 && s_ack);
      chk("m0_err", d_m0_err, !rst && mg == 2'b01 && (s_err || exp_to));
      chk("m1_err", d_m1_err, !rst && mg == 2'b10 && (s_err || exp_to));
      chk("m0_dat", d_m0_dat, s_dat);
      chk("m1_dat", d_m1_dat, s_dat);
      chk("fp_gnt", f_gnt, mg_fp);
      chk("fp_s_cyc", f_s_cyc, fp_cyc);
      chk("fp_s_stb", f_s_stb, fp_stb);
      chk("fp_s_adr", {f_s_we, f_s_sel, f_s_adr, f_s_dat},
          (mg_fp == 2'b10) ? {m1_we, m1_sel, m1_adr, m1_dat} : {m0_we, m0_sel, m0_adr, m0_dat});
      chk("fp_m0_ack", f_m0_ack, !rst && mg_fp == 2'b01 && s_ack);
      chk("fp_m1_ack", f_m1_ack, !rst && mg_fp == 2'b10 && s_ack);
      chk("fp_m0_err", f_m0_err, !rst && mg_fp == 2'b01 && s_err);
      chk("fp_m1_err", f_m1_err, !rst && mg_fp == 2'b10 && s_err);
      chk("fp_dat", {f_m0_dat, f_m1_dat}, {s_dat, s_dat});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drop_all();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    s_ack = 1'b0; s_err = 1'b0;
  endtask

  logic [1:0] exp_rr [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  int first_err, n_err, n_ack;

  initial begin
    repeat (2) step();
    chk_on = 1'b1;
    chk("rst_gnt", d_gnt, 2'b00);
    chk("rst_scyc", {d_s_cyc, d_s_stb}, 2'b00);
    chk("rst_acks", {d_m0_ack, d_m0_err, d_m1_ack, d_m1_err}, 4'b0000);
    rst = 1'b0;

    // m0 single read, one wait state, data 0x1234
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0010;
    settle();
    chk("t1_latency", d_gnt, 2'b00);
    step();
    chk("t1_gnt", d_gnt, 2'b01);
    chk("t1_sadr", d_s_adr, 16'h0010);
    step();
    s_ack = 1'b1; s_dat = 16'h1234;
    settle();
    chk("t1_ack", {d_m0_ack, d_m1_ack}, 2'b10);
    chk("t1_dat", d_m0_dat, 16'h1234);
    step();
    drop_all();
    step();
    chk("t1_idle", d_gnt, 2'b00);

    // m1 write answered with slave err
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 16'h0200; m1_dat = 16'hBEEF; m1_sel = 2'b01;
    step();
    chk("err_gnt", d_gnt, 2'b10);
    s_err = 1'b1;
    settle();
    chk("err_route", {d_m1_err, d_m0_err, d_m1_ack}, 3'b100);
    step();
    drop_all(); m1_sel = 2'b11;
    repeat (2) step();

    // tie rounds after a fresh reset: round-robin alternates, fixed picks m0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'(16'h0020 + r);
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 16'(16'h0040 + r);
      step();
      chk("rr_gnt", d_gnt, exp_rr[r]);
      chk("fp_gnt_tie", f_gnt, 2'b01);
      s_ack = 1'b1;
      settle();
      chk("rr_ack", {d_m1_ack, d_m0_ack}, exp_rr[r]);
      step();
      drop_all();
      step();
      chk("rr_idle", d_gnt, 2'b00);
    end

    // m1 4-word burst with stb toggling while m0 waits
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 16'h0100;
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0030;
    for (int w = 0; w < 4; w++) begin
      m1_adr = 16'(16'h0100 + w); m1_stb = 1'b1;
      s_ack = 1'b1; s_dat = 16'(16'hA000 + w);
      settle();
      chk("burst_gnt", d_gnt, 2'b10);
      chk("burst_adr", d_s_adr, 32'(16'h0100 + w));
      chk("burst_ack", {d_m1_ack, d_m0_ack}, 2'b10);
      step();
      m1_stb = 1'b0; s_ack = 1'b0;
      step();
      chk("burst_hold", d_gnt, 2'b10);
    end
    m1_cyc = 1'b0;
    step();
    chk("burst_idle", d_gnt, 2'b00);
    step();
    chk("burst_m0", d_gnt, 2'b01);
    s_ack = 1'b1;
    settle();
    chk("burst_m0_ack", d_m0_ack, 1'b1);
    step();
    drop_all();
    repeat (2) step();

    // watchdog: slave never answers
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0050;
    step();
    first_err = 0; n_err = 0; n_ack = 0;
    for (int i = 1; i <= 12; i++) begin
      settle();
      if (d_m0_err) begin
        n_err++;
        if (first_err == 0) first_err = i;
      end
      if (d_m0_ack) n_ack++;
      step();
    end
    chk("to_cycle", first_err, 8);
    chk("to_pulses", n_err, 1);
    chk("to_noack", n_ack, 0);
    drop_all();
    repeat (2) step();

    // ack lands exactly on the timeout cycle
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0051;
    step();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) s_ack = 1'b1;
      settle();
      if (i == 8) chk("to_race", {d_m0_ack, d_m0_err}, 2'b10);
      step();
    end
    drop_all();
    repeat (2) step();

    // reset while m1 owns the bus with a pending strobe
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 16'h0060;
    step();
    chk("rst_pre_gnt", d_gnt, 2'b10);
    step();
    rst = 1'b1; s_ack = 1'b1;
    settle();
    chk("rst_ack_drop", {d_m0_ack, d_m1_ack, d_m0_err, d_m1_err}, 4'b0000);
    step();
    chk("rst_gnt_drop", d_gnt, 2'b00);
    chk("rst_scyc_drop", d_s_cyc, 1'b0);
    rst = 1'b0; s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0070;
    step();
    chk("rst_after_gnt", d_gnt, 2'b01);
    s_ack = 1'b1; s_dat = 16'h5A5A;
    settle();
    chk("rst_after_ack", {d_m0_ack, d_m0_dat}, {1'b1, 16'h5A5A});
    step();
    drop_all();
    repeat (3) step();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
